keypad_scan: RTL

- Multiplexed 4x4 hex keypad scanner; the input-side counterpart of the 4-digit 7-segment display driver.
- Drives one active-low column line at a time and samples four active-low row lines.
- Debounces presses and accepts only single-key events.
- Shifts each accepted hex digit into a 16-bit value so the display driver can show it directly.

---
 rtl/keypad_scan.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 hex keypad scanner with debounce and digit shift register
//
// Purpose:
//   Sweeps four active-low column lines one at a time and samples the
//   active-low row lines at the end of each column dwell. The sample
//   matrix is evaluated once per sweep. A key is accepted only when it is
//   the single closed key for DEBOUNCE_SCANS consecutive sweeps. Another
//   press is accepted only after the matrix has been empty for
//   DEBOUNCE_SCANS consecutive sweeps. Each accepted hex code is shifted
//   into a 16-bit value, with the newest digit in [3:0].
//
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous active-high reset
//   colsel_o[3:0] active-low column drive (exactly one bit low)
//   row_i[3:0]   active-low row sense (externally pulled up)
//   clear_i      synchronous clear of data_o
//   data_o[15:0] last four accepted digits, newest in [3:0]
//   key_o[3:0]   code of the most recently accepted key (4*row+col)
//   key_valid_o  one-cycle pulse per accepted press
module keypad_scan #(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [3:0]  colsel_o,
  input  logic [3:0]  row_i,
  input  logic        clear_i,
  output logic [15:0] data_o,
  output logic [3:0]  key_o,
  output logic        key_valid_o
);

  localparam int         CW      = SCAN_DIV_BITS + 2;
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  logic [CW-1:0] scan_q;
  logic [15:0]   raw_q, raw_d;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic [15:0]   data_q;
  logic [3:0]    key_q;
  logic          key_valid_q;

  logic [1:0]    col;
  logic          sample;
  logic          eval;
  logic          any_set, multi_set;
  logic [3:0]    hit_code;
  logic          is_none, is_single;
  logic [3:0]    dcnt_inc;
  logic          accept;
  logic [3:0]    acc_code;

  assign col      = scan_q[CW-1 -: 2];
  // Sample on the last cycle of each dwell so the lines have settled.
  assign sample   = &scan_q[SCAN_DIV_BITS-1:0];
  assign eval     = sample && (col == 2'd3);
  assign colsel_o = ~(4'b0001 << col);
  assign dcnt_inc = dcnt_q + 4'd1;

  // Matrix with the samples of this edge merged in, so the sweep
  // evaluation sees the column-3 rows taken on the same edge.
  always_comb begin
    raw_d = raw_q;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        raw_d[{2'(r), col}] = ~row_i[r];
      end
    end
  end

  always_comb begin
    any_set   = 1'b0;
    multi_set = 1'b0;
    hit_code  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (raw_d[i]) begin
        if (any_set) multi_set = 1'b1;
        any_set  = 1'b1;
        hit_code = 4'(i);
      end
    end
  end

  assign is_none   = !any_set;
  assign is_single = any_set && !multi_set;

  // State register and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      scan_q      <= '0;
      raw_q       <= '0;
      state_q     <= IDLE;
      cand_q      <= 4'h0;
      dcnt_q      <= 4'h0;
      data_q      <= 16'h0000;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      scan_q      <= scan_q + 1'b1;
      raw_q       <= raw_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      dcnt_q      <= dcnt_d;
      key_valid_q <= accept;
      if (accept) begin
        key_q  <= acc_code;
        data_q <= clear_i ? {12'h000, acc_code} : {data_q[11:0], acc_code};
      end else if (clear_i) begin
        data_q <= 16'h0000;
      end
    end
  end

  // Next-state logic, evaluated once per sweep
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dcnt_d  = dcnt_q;
    if (eval) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d  = hit_code;
            dcnt_d  = 4'd1;
            state_d = (DB_LAST == 4'd1) ? HELD : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (is_single && hit_code == cand_q) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc >= DB_LAST) state_d = HELD;
          end else if (is_single) begin
            cand_d = hit_code;
            dcnt_d = 4'd1;
          end else begin
            state_d = IDLE;
            dcnt_d  = 4'd0;
          end
        end
        HELD: begin
          if (is_none) begin
            dcnt_d  = 4'd1;
            state_d = (DB_LAST == 4'd1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (is_none) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc >= DB_LAST) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Accept decode: only a debounced single key leaving IDLE/DEBOUNCE
  always_comb begin
    accept   = 1'b0;
    acc_code = cand_q;
    if (eval && is_single) begin
      if (state_q == IDLE && DB_LAST == 4'd1) begin
        accept   = 1'b1;
        acc_code = hit_code;
      end else if (state_q == DEBOUNCE && hit_code == cand_q && dcnt_inc >= DB_LAST) begin
        accept = 1'b1;
      end
    end
  end

  assign data_o      = data_q;
  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;

endmodule
